// File: rtl/jogo_pkg.sv
// ============================================================================
// jogo_pkg : state codes, bank reset pattern and width helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        PREPARA = 4'h1,
        GRAVA   = 4'h2,
        MOSTRA  = 4'h3,
        ESPERA  = 4'h4,
        COMPARA = 4'h5,
        PROX    = 4'h6,
        RODADA  = 4'h7,
        FIM_G   = 4'h8,
        FIM_P   = 4'h9,
        FIM_T   = 4'hA
    } estado_t;

    function automatic int clog2(input int valor);
        int r;
        r = 0;
        while ((1 << r) < valor) r++;
        return r;
    endfunction

    // Never returns zero, so a 1-entry dimension still gets a 1-bit select
    function automatic int larg(input int valor);
        return (clog2(valor) < 1) ? 1 : clog2(valor);
    endfunction

    // Lit button index for bank b, entry i after reset
    function automatic int unsigned bit_padrao(input int banco, input int entrada, input int n_botoes);
        return (banco + entrada) % n_botoes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/banco_sequencias.sv
// ============================================================================
// banco_sequencias : N_MEM x PROF x N_BOTOES sequence store, sync write / comb read
// Rev 1.0
// ============================================================================
`default_nettype none

module banco_sequencias
    import jogo_pkg::*;
#(
    parameter int N_BOTOES = 4,
    parameter int PROF     = 16,
    parameter int N_MEM    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      escreve,
    input  logic [larg(N_MEM)-1:0]    banco_esc,
    input  logic [larg(PROF)-1:0]     end_esc,
    input  logic [N_BOTOES-1:0]       dado_esc,
    input  logic [larg(N_MEM)-1:0]    banco_le,
    input  logic [larg(PROF)-1:0]     end_le,
    output logic [N_BOTOES-1:0]       dado_le
);

    logic [N_BOTOES-1:0] mem [N_MEM][PROF];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int b = 0; b < N_MEM; b++) begin
                for (int i = 0; i < PROF; i++) begin
                    mem[b][i] <= N_BOTOES'(1) << bit_padrao(b, i, N_BOTOES);
                end
            end
        end else if (escreve) begin
            mem[banco_esc][end_esc] <= dado_esc;
        end
    end

    assign dado_le = mem[banco_le][end_le];

endmodule

`default_nettype wire

// File: rtl/jogo_seq_param.sv
// ============================================================================
// jogo_seq_param : parametrised memory game with record mode, cumulative rounds,
//                  selectable timeout and saturating scoreboards
// Rev 1.0
// ============================================================================
`default_nettype none

module jogo_seq_param
    import jogo_pkg::*;
#(
    parameter int N_BOTOES       = 4,
    parameter int PROF           = 16,
    parameter int N_MEM          = 4,
    parameter int CICLOS_MOSTRA  = 50000,
    parameter int CICLOS_TIMEOUT = 100000,
    parameter int LARG_PLACAR    = 7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     jogar,
    input  logic [N_BOTOES-1:0]      botoes,
    input  logic [1:0]               nivel,
    input  logic [larg(N_MEM)-1:0]   memoria,
    input  logic                     quer_escrever,
    input  logic [1:0]               timeoutD,
    input  logic                     ignora_timeout,
    output logic                     ganhou,
    output logic                     perdeu,
    output logic                     timeout,
    output logic                     pronto,
    output logic [N_BOTOES-1:0]      leds,
    output logic                     buzzer,
    output logic [LARG_PLACAR-1:0]   vitorias,
    output logic [LARG_PLACAR-1:0]   derrotas,
    output logic [3:0]               db_estado
);

    localparam int MW     = larg(N_MEM);
    localparam int AW     = larg(PROF);
    localparam int LW     = AW + 1;
    localparam int SOMA_W = LW + 1;
    localparam int SW     = larg(CICLOS_MOSTRA);
    localparam int TW     = larg(4 * CICLOS_TIMEOUT + 1);

    localparam logic [AW-1:0] END_MAX = AW'(PROF - 1);
    localparam logic [SW-1:0] CNT_MAX = SW'(CICLOS_MOSTRA - 1);
    localparam logic [SW-1:0] CNT_MEIO = SW'(CICLOS_MOSTRA / 2);

    estado_t estado, estado_prox;

    logic                jogar_ant, jogar_ev;
    logic                botao_ant, jogada;
    logic [N_BOTOES-1:0] bot_cap, jog_val, dado_le;
    logic [MW-1:0]       cfg_mem;
    logic                cfg_grava;
    logic [1:0]          cfg_nivel, cfg_tmo;
    logic [AW-1:0]       end_r;
    logic [LW-1:0]       limite, lim_ini, lim_prox;
    logic [SOMA_W-1:0]   soma_ini, soma_rodada;
    logic [SW-1:0]       cnt_mostra;
    logic [TW-1:0]       timer, lim_tmo;
    logic                ultimo;

    banco_sequencias #(
        .N_BOTOES (N_BOTOES),
        .PROF     (PROF),
        .N_MEM    (N_MEM)
    ) u_banco (
        .clock     (clock),
        .reset     (reset),
        .escreve   ((estado == GRAVA) && jogada),
        .banco_esc (cfg_mem),
        .end_esc   (end_r),
        .dado_esc  (bot_cap),
        .banco_le  (cfg_mem),
        .end_le    (end_r),
        .dado_le   (dado_le)
    );

    // Round lengths clamp at PROF; sums carry one spare bit to detect overflow
    assign soma_ini    = SOMA_W'(cfg_nivel) + SOMA_W'(1);
    assign soma_rodada = SOMA_W'(limite) + SOMA_W'(cfg_nivel) + SOMA_W'(1);
    assign lim_ini     = (soma_ini > SOMA_W'(PROF)) ? LW'(PROF) : soma_ini[LW-1:0];
    assign lim_prox    = (soma_rodada > SOMA_W'(PROF)) ? LW'(PROF) : soma_rodada[LW-1:0];
    assign lim_tmo     = TW'(CICLOS_TIMEOUT) * (TW'(cfg_tmo) + TW'(1)) - TW'(1);
    assign ultimo      = (LW'(end_r) == (limite - LW'(1)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIAL, FIM_G, FIM_P, FIM_T: if (jogar_ev) estado_prox = PREPARA;
            PREPARA: estado_prox = cfg_grava ? GRAVA : MOSTRA;
            GRAVA:   if (jogada && end_r == END_MAX) estado_prox = INICIAL;
            MOSTRA:  if (cnt_mostra == CNT_MAX && ultimo) estado_prox = ESPERA;
            ESPERA: begin
                if (jogada)
                    estado_prox = COMPARA;
                else if (timer == lim_tmo && !ignora_timeout)
                    estado_prox = FIM_T;
            end
            COMPARA: begin
                if (jog_val != dado_le)
                    estado_prox = FIM_P;
                else if (ultimo)
                    estado_prox = (limite == LW'(PROF)) ? FIM_G : RODADA;
                else
                    estado_prox = PROX;
            end
            PROX:    estado_prox = ESPERA;
            RODADA:  estado_prox = MOSTRA;
            default: estado_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            jogar_ant  <= 1'b0;
            jogar_ev   <= 1'b0;
            botao_ant  <= 1'b0;
            jogada     <= 1'b0;
            bot_cap    <= '0;
            jog_val    <= '0;
            cfg_mem    <= '0;
            cfg_grava  <= 1'b0;
            cfg_nivel  <= '0;
            cfg_tmo    <= '0;
            end_r      <= '0;
            limite     <= '0;
            cnt_mostra <= '0;
            timer      <= '0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            timeout    <= 1'b0;
            pronto     <= 1'b0;
            vitorias   <= '0;
            derrotas   <= '0;
        end else begin
            jogar_ant <= jogar;
            jogar_ev  <= jogar & ~jogar_ant;
            botao_ant <= |botoes;
            jogada    <= (|botoes) & ~botao_ant;
            bot_cap   <= botoes;

            case (estado)
                INICIAL, FIM_G, FIM_P, FIM_T: begin
                    if (jogar_ev) begin
                        cfg_mem   <= memoria;
                        cfg_grava <= quer_escrever;
                        cfg_nivel <= nivel;
                        cfg_tmo   <= timeoutD;
                    end
                end
                PREPARA: begin
                    ganhou     <= 1'b0;
                    perdeu     <= 1'b0;
                    timeout    <= 1'b0;
                    pronto     <= 1'b0;
                    end_r      <= '0;
                    cnt_mostra <= '0;
                    timer      <= '0;
                    limite     <= lim_ini;
                end
                GRAVA: begin
                    if (jogada) begin
                        if (end_r == END_MAX)
                            pronto <= 1'b1;
                        else
                            end_r <= end_r + AW'(1);
                    end
                end
                MOSTRA: begin
                    if (cnt_mostra == CNT_MAX) begin
                        cnt_mostra <= '0;
                        if (ultimo) begin
                            end_r <= '0;
                            timer <= '0;
                        end else begin
                            end_r <= end_r + AW'(1);
                        end
                    end else begin
                        cnt_mostra <= cnt_mostra + SW'(1);
                    end
                end
                ESPERA: begin
                    // With ignora_timeout set the timer parks at its limit
                    if (jogada)
                        jog_val <= bot_cap;
                    else if (timer != lim_tmo)
                        timer <= timer + TW'(1);
                end
                PROX: begin
                    end_r <= end_r + AW'(1);
                    timer <= '0;
                end
                RODADA: begin
                    limite     <= lim_prox;
                    end_r      <= '0;
                    cnt_mostra <= '0;
                end
                default: ;
            endcase

            if (estado_prox != estado) begin
                case (estado_prox)
                    FIM_G: begin
                        ganhou <= 1'b1;
                        pronto <= 1'b1;
                        if (vitorias != '1) vitorias <= vitorias + LARG_PLACAR'(1);
                    end
                    FIM_P: begin
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                        if (derrotas != '1) derrotas <= derrotas + LARG_PLACAR'(1);
                    end
                    FIM_T: begin
                        timeout <= 1'b1;
                        perdeu  <= 1'b1;
                        pronto  <= 1'b1;
                        if (derrotas != '1) derrotas <= derrotas + LARG_PLACAR'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        leds = '0;
        case (estado)
            MOSTRA:  if (cnt_mostra < CNT_MEIO) leds = dado_le;
            GRAVA:   if (jogada) leds = bot_cap;
            COMPARA: leds = jog_val;
            default: leds = '0;
        endcase
    end

    assign buzzer    = |leds;
    assign db_estado = estado;

endmodule

`default_nettype wire

// File: tb/tb_jogo_seq_param.sv
// ============================================================================
// tb_jogo_seq_param : directed self-checking bench for jogo_seq_param
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jogo_seq_param;

    localparam logic [3:0] S_INICIAL = 4'h0;
    localparam logic [3:0] S_PREPARA = 4'h1;
    localparam logic [3:0] S_MOSTRA  = 4'h3;
    localparam logic [3:0] S_ESPERA  = 4'h4;
    localparam logic [3:0] S_FIM_G   = 4'h8;
    localparam logic [3:0] S_FIM_P   = 4'h9;
    localparam logic [3:0] S_FIM_T   = 4'hA;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic [3:0] botoes = '0;
    logic [1:0] nivel = '0;
    logic [1:0] memoria = '0;
    logic       quer_escrever = 1'b0;
    logic [1:0] timeoutD = '0;
    logic       ignora_timeout = 1'b0;
    logic       ganhou, perdeu, timeout, pronto, buzzer;
    logic [3:0] leds, db_estado;
    logic [6:0] vitorias, derrotas;

    int total = 0;
    int passados = 0;
    int falhas = 0;

    jogo_seq_param #(
        .N_BOTOES       (4),
        .PROF           (8),
        .N_MEM          (4),
        .CICLOS_MOSTRA  (4),
        .CICLOS_TIMEOUT (20),
        .LARG_PLACAR    (7)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .jogar          (jogar),
        .botoes         (botoes),
        .nivel          (nivel),
        .memoria        (memoria),
        .quer_escrever  (quer_escrever),
        .timeoutD       (timeoutD),
        .ignora_timeout (ignora_timeout),
        .ganhou         (ganhou),
        .perdeu         (perdeu),
        .timeout        (timeout),
        .pronto         (pronto),
        .leds           (leds),
        .buzzer         (buzzer),
        .vitorias       (vitorias),
        .derrotas       (derrotas),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    task automatic ciclo(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        assert (obs === esp) passados++;
        else begin
            falhas++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, esp);
        end
    endtask

    task automatic esperar(input logic [3:0] alvo, input int limite, output int n);
        n = 0;
        while (db_estado !== alvo && n < limite) begin
            ciclo(1);
            n++;
        end
        chk($sformatf("chega_estado_%0h", alvo), 32'(db_estado), 32'(alvo));
    endtask

    task automatic pulso_jogar();
        jogar = 1'b1;
        ciclo(1);
        jogar = 1'b0;
        ciclo(1);
    endtask

    task automatic apertar(input logic [3:0] v);
        botoes = v;
        ciclo(1);
        botoes = '0;
        ciclo(1);
    endtask

    initial begin
        int n;
        logic [3:0] seq [8];
        int lims [3];

        seq[0] = 4'b1000; seq[1] = 4'b0100; seq[2] = 4'b0010; seq[3] = 4'b0001;
        seq[4] = 4'b1000; seq[5] = 4'b0100; seq[6] = 4'b0010; seq[7] = 4'b0001;
        lims[0] = 3; lims[1] = 6; lims[2] = 8;

        // Reset state and reload pattern
        reset = 1'b0;
        ciclo(2);
        reset = 1'b1;
        chk("reset_estado", 32'(db_estado), 32'(S_INICIAL));
        chk("reset_vitorias", 32'(vitorias), 0);
        chk("reset_derrotas", 32'(derrotas), 0);
        chk("reset_leds", 32'(leds), 0);
        chk("reset_pronto", 32'(pronto), 0);
        chk("reset_banco1_e0", 32'(dut.u_banco.mem[1][0]), 32'(4'b0010));

        // Record mode into bank 3
        quer_escrever = 1'b1;
        memoria = 2'd3;
        pulso_jogar();
        chk("prepara", 32'(db_estado), 32'(S_PREPARA));
        botoes = seq[0];
        ciclo(1);
        chk("grava_eco", 32'(leds), 32'(seq[0]));
        botoes = '0;
        ciclo(1);
        for (int i = 1; i < 8; i++) apertar(seq[i]);
        chk("grava_fim_estado", 32'(db_estado), 32'(S_INICIAL));
        chk("grava_pronto", 32'(pronto), 1);
        chk("grava_vitorias", 32'(vitorias), 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("banco3_e%0d", i), 32'(dut.u_banco.mem[3][i]), 32'(seq[i]));

        // Full win: rounds of 3, 6 and 8 elements
        quer_escrever = 1'b0;
        nivel = 2'd2;
        pulso_jogar();
        for (int r = 0; r < 3; r++) begin
            esperar(S_MOSTRA, 20, n);
            if (r == 0) begin
                chk("mostra_led0", 32'(leds), 32'(seq[0]));
                chk("mostra_buzzer", 32'(buzzer), 1);
                ciclo(2);
                chk("mostra_apagado", 32'(leds), 0);
            end
            esperar(S_ESPERA, 100, n);
            if (r == 2) chk("duracao_mostra_r3", 32'(n), 32);
            for (int k = 0; k < lims[r]; k++) begin
                if (k > 0) esperar(S_ESPERA, 20, n);
                apertar(seq[k]);
                if (r == 0 && k == 0) chk("eco_compara", 32'(leds), 32'(seq[0]));
            end
        end
        esperar(S_FIM_G, 10, n);
        chk("vitoria_ganhou", 32'(ganhou), 1);
        chk("vitoria_pronto", 32'(pronto), 1);
        chk("vitoria_perdeu", 32'(perdeu), 0);
        chk("vitoria_placar", 32'(vitorias), 1);

        // Wrong second press
        pulso_jogar();
        esperar(S_ESPERA, 100, n);
        apertar(4'b1000);
        esperar(S_ESPERA, 20, n);
        apertar(4'b0001);
        esperar(S_FIM_P, 10, n);
        chk("erro_perdeu", 32'(perdeu), 1);
        chk("erro_ganhou", 32'(ganhou), 0);
        chk("erro_derrotas", 32'(derrotas), 1);
        chk("erro_vitorias", 32'(vitorias), 1);

        // Timeout with multiplier 2
        timeoutD = 2'd1;
        pulso_jogar();
        esperar(S_ESPERA, 100, n);
        esperar(S_FIM_T, 100, n);
        chk("timeout_ciclos", 32'(n), 40);
        chk("timeout_flag", 32'(timeout), 1);
        chk("timeout_perdeu", 32'(perdeu), 1);
        chk("timeout_derrotas", 32'(derrotas), 2);

        // Timeout ignored
        ignora_timeout = 1'b1;
        pulso_jogar();
        esperar(S_ESPERA, 100, n);
        ciclo(200);
        chk("ignora_estado", 32'(db_estado), 32'(S_ESPERA));
        chk("ignora_timeout_flag", 32'(timeout), 0);
        apertar(4'b0001);
        esperar(S_FIM_P, 10, n);
        chk("ignora_derrotas", 32'(derrotas), 3);
        ignora_timeout = 1'b0;
        timeoutD = 2'd0;

        // Reset during MOSTRA
        pulso_jogar();
        esperar(S_MOSTRA, 20, n);
        ciclo(1);
        reset = 1'b0;
        ciclo(1);
        chk("reset_meio_estado", 32'(db_estado), 32'(S_INICIAL));
        chk("reset_meio_leds", 32'(leds), 0);
        chk("reset_meio_derrotas", 32'(derrotas), 0);
        chk("reset_meio_banco3_e1", 32'(dut.u_banco.mem[3][1]), 32'(4'b0001));
        reset = 1'b1;
        ciclo(1);

        // Multi-bit press never matches
        pulso_jogar();
        esperar(S_ESPERA, 100, n);
        apertar(4'b0011);
        esperar(S_FIM_P, 10, n);
        chk("multibit_perdeu", 32'(perdeu), 1);
        chk("multibit_ganhou", 32'(ganhou), 0);
        chk("multibit_derrotas", 32'(derrotas), 1);

        $display("%0d/%0d checks passed", passados, total);
        $finish;
    end

endmodule

`default_nettype wire
